// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch selector codes, instruction field positions, phase encoding.
package cpu_pkg;

    localparam logic [2:0] BR_SEQ  = 3'd0;
    localparam logic [2:0] BR_SKIP = 3'd1;
    localparam logic [2:0] BR_LOOP = 3'd2;
    localparam logic [2:0] BR_JREG = 3'd3;
    localparam logic [2:0] BR_BZ   = 3'd4;
    localparam logic [2:0] BR_MARK = 3'd5;
    localparam logic [2:0] BR_HALT = 3'd6;
    localparam logic [2:0] BR_RSVD = 3'd7;

    localparam int unsigned OPCODE_MSB = 15;
    localparam int unsigned OPCODE_LSB = 12;
    localparam int unsigned RI1_MSB    = 11;
    localparam int unsigned RI1_LSB    = 8;
    localparam int unsigned SPARE_BIT  = 7;
    localparam int unsigned ARG2_BIT   = 6;
    localparam int unsigned RI2_MSB    = 5;
    localparam int unsigned RI2_LSB    = 0;
    localparam int unsigned F51_MSB    = 5;
    localparam int unsigned F51_LSB    = 1;
    localparam int unsigned O10_MSB    = 1;
    localparam int unsigned O10_LSB    = 0;
    localparam int unsigned BIT0_BIT   = 0;

    typedef enum logic {
        PH_EXEC   = 1'b0,
        PH_SECOND = 1'b1
    } phase_e;

endpackage

// File: rtl/fetch_sequencer_next_pc_mux.sv
// Combinational next-PC selector driven by Control's branch_dest code.
module next_pc_mux
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned HALT_PC = 200
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic [2:0]      branch_dest_i,
    input  logic            alu_zero_i,
    input  logic [PC_W-1:0] jump_target_i,
    input  logic [PC_W-1:0] loop_start_i,
    output logic [PC_W-1:0] next_pc_c_o,
    output logic            mark_c_o,
    output logic            halt_c_o
);

    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] pc_plus2;

    // Sequential successors wrap naturally at PC_W bits.
    assign pc_plus1 = pc_i + PC_W'(1);
    assign pc_plus2 = pc_i + PC_W'(2);

    // Select the successor PC; reserved code behaves as sequential.
    always_comb begin
        next_pc_c_o = pc_plus1;
        mark_c_o    = 1'b0;
        halt_c_o    = 1'b0;
        case (branch_dest_i)
            BR_SKIP: if (alu_zero_i) next_pc_c_o = pc_plus2;
            BR_LOOP: next_pc_c_o = loop_start_i;
            BR_JREG: next_pc_c_o = jump_target_i;
            BR_BZ:   if (alu_zero_i) next_pc_c_o = jump_target_i;
            BR_MARK: mark_c_o = 1'b1;
            BR_HALT: begin
                next_pc_c_o = PC_W'(HALT_PC);
                halt_c_o    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch / PC sequencer: field slicing, hold phasing, halt, loop mark, retire count.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned HALT_PC  = 200,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic [2:0]         branch_dest,
    input  logic               hold,
    input  logic               alu_zero,
    input  logic [PC_W-1:0]    jump_target,
    output logic [3:0]         opcode,
    output logic [3:0]         read_i1_write_i,
    output logic               arg2,
    output logic [5:0]         read_i2_write_d_write_data,
    output logic [4:0]         five_to_one,
    output logic [1:0]         one_to_zero,
    output logic               bit0,
    output logic               phase,
    output logic               halted,
    output logic [CNT_W-1:0]   retired
);

    phase_e          phase_q, phase_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] loop_start_q, loop_start_d;
    logic            halted_q, halted_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic [PC_W-1:0] next_pc;
    logic            mark;
    logic            halt_req;
    logic            unused_spare;

    // Zero-latency field slices of the fetched word.
    assign opcode                     = imem_rdata[OPCODE_MSB:OPCODE_LSB];
    assign read_i1_write_i            = imem_rdata[RI1_MSB:RI1_LSB];
    assign arg2                       = imem_rdata[ARG2_BIT];
    assign read_i2_write_d_write_data = imem_rdata[RI2_MSB:RI2_LSB];
    assign five_to_one                = imem_rdata[F51_MSB:F51_LSB];
    assign one_to_zero                = imem_rdata[O10_MSB:O10_LSB];
    assign bit0                       = imem_rdata[BIT0_BIT];
    assign unused_spare               = imem_rdata[SPARE_BIT];

    assign imem_addr = pc_q;
    assign phase     = phase_q;
    assign halted    = halted_q;
    assign retired   = retired_q;

    next_pc_mux #(
        .PC_W    (PC_W),
        .HALT_PC (HALT_PC)
    ) u_next_pc_mux (
        .pc_i          (pc_q),
        .branch_dest_i (branch_dest),
        .alu_zero_i    (alu_zero),
        .jump_target_i (jump_target),
        .loop_start_i  (loop_start_q),
        .next_pc_c_o   (next_pc),
        .mark_c_o      (mark),
        .halt_c_o      (halt_req)
    );

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= PC_W'(RESET_PC);
            phase_q      <= PH_EXEC;
            halted_q     <= 1'b0;
            loop_start_q <= PC_W'(RESET_PC);
            retired_q    <= '0;
        end else begin
            pc_q         <= pc_d;
            phase_q      <= phase_d;
            halted_q     <= halted_d;
            loop_start_q <= loop_start_d;
            retired_q    <= retired_d;
        end
    end

    // Next state: halt and stall freeze everything; a hold defers retirement by one cycle.
    always_comb begin
        pc_d         = pc_q;
        phase_d      = phase_q;
        halted_d     = halted_q;
        loop_start_d = loop_start_q;
        retired_d    = retired_q;
        if (!halted_q && !stall) begin
            if (phase_q == PH_EXEC && hold) begin
                phase_d = PH_SECOND;
            end else begin
                phase_d   = PH_EXEC;
                pc_d      = next_pc;
                retired_d = (retired_q == {CNT_W{1'b1}}) ? retired_q : retired_q + CNT_W'(1);
                if (mark)     loop_start_d = next_pc;
                if (halt_req) halted_d = 1'b1;
            end
        end
    end

endmodule
